// File: rtl/vga_pkg.sv
// Shared geometry, control codes and FSM states for the VGA text console writer.
package vga_pkg;

  localparam logic [6:0]  COLS        = 7'd80;
  localparam logic [4:0]  ROWS        = 5'd25;
  localparam logic [11:0] ROW_BYTES   = 12'd160;
  localparam logic [11:0] TEXT_BYTES  = 12'd4000;

  localparam logic [6:0]  LAST_COL    = COLS - 7'd1;
  localparam logic [4:0]  LAST_ROW    = ROWS - 5'd1;
  localparam logic [11:0] LAST_ADDR   = TEXT_BYTES - 12'd1;
  // Last destination byte of the scroll copy; the final row is filled afterwards.
  localparam logic [11:0] SCROLL_LAST = TEXT_BYTES - ROW_BYTES - 12'd1;

  localparam logic [7:0]  CH_BS       = 8'h08;
  localparam logic [7:0]  CH_TAB      = 8'h09;
  localparam logic [7:0]  CH_LF       = 8'h0A;
  localparam logic [7:0]  CH_CR       = 8'h0D;
  localparam logic [7:0]  CH_SPACE    = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    WR_CHAR,
    WR_ATTR,
    SCROLL_RD,
    SCROLL_WR,
    FILL
  } state_e;

endpackage

// File: rtl/vga_console_addr.sv
// Maps a cursor position to the byte address of its character cell (attribute is +1).
module vga_console_addr
  import vga_pkg::*;
(
  input  logic [6:0]  x,
  input  logic [4:0]  y,
  output logic [11:0] addr
);

  assign addr = 12'(y) * ROW_BYTES + {4'b0, x, 1'b0};

endmodule

// File: rtl/vga_console_writer.sv
// Character stream to 80x25 text memory writer with cursor control, scrolling and clear.
module vga_console_writer
  import vga_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  attr,
  input  logic        clear,
  output logic [11:0] mem_a,
  output logic [7:0]  mem_dw,
  output logic        mem_we,
  input  logic [7:0]  mem_dr,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [11:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dw_q, mem_dw_d;
  logic        mem_we_q, mem_we_d;
  logic [6:0]  cursor_x_q, cursor_x_d;
  logic [4:0]  cursor_y_q, cursor_y_d;
  logic [7:0]  attr_q, attr_d;
  logic        clr_q, clr_d;

  logic [11:0] cell_addr;
  logic [6:0]  tab_x;
  logic        newline;

  vga_console_addr u_addr (
    .x    (cursor_x_q),
    .y    (cursor_y_q),
    .addr (cell_addr)
  );

  assign tab_x = (cursor_x_q | 7'd7) + 7'd1;

  always_comb begin
    state_d    = state_q;
    mem_a_d    = mem_a_q;
    mem_dw_d   = mem_dw_q;
    mem_we_d   = 1'b0;
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    attr_d     = attr_q;
    clr_d      = clr_q;
    newline    = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear) begin
          attr_d   = attr;
          clr_d    = 1'b1;
          state_d  = FILL;
          mem_a_d  = 12'd0;
          mem_dw_d = CH_SPACE;
          mem_we_d = 1'b1;
        end else if (in_valid) begin
          attr_d = attr;
          case (in_data)
            CH_CR:  cursor_x_d = 7'd0;
            CH_BS:  if (cursor_x_q != 7'd0) cursor_x_d = cursor_x_q - 7'd1;
            CH_LF:  newline = 1'b1;
            CH_TAB: begin
              if (tab_x >= COLS) newline = 1'b1;
              else cursor_x_d = tab_x;
            end
            default: begin
              state_d  = WR_CHAR;
              mem_a_d  = cell_addr;
              mem_dw_d = in_data;
              mem_we_d = 1'b1;
            end
          endcase
        end
      end
      WR_CHAR: begin
        state_d  = WR_ATTR;
        mem_a_d  = mem_a_q + 12'd1;
        mem_dw_d = attr_q;
        mem_we_d = 1'b1;
      end
      WR_ATTR: begin
        state_d = IDLE;
        if (cursor_x_q == LAST_COL) newline = 1'b1;
        else cursor_x_d = cursor_x_q + 7'd1;
      end
      SCROLL_RD: begin
        state_d  = SCROLL_WR;
        mem_a_d  = mem_a_q - ROW_BYTES;
        mem_we_d = 1'b1;
      end
      SCROLL_WR: begin
        if (mem_a_q == SCROLL_LAST) begin
          state_d  = FILL;
          mem_a_d  = SCROLL_LAST + 12'd1;
          mem_dw_d = CH_SPACE;
          mem_we_d = 1'b1;
        end else begin
          state_d = SCROLL_RD;
          mem_a_d = mem_a_q + ROW_BYTES + 12'd1;
        end
      end
      FILL: begin
        if (mem_a_q == LAST_ADDR) begin
          state_d    = IDLE;
          cursor_x_d = 7'd0;
          if (clr_q) cursor_y_d = 5'd0;
        end else begin
          mem_a_d  = mem_a_q + 12'd1;
          mem_dw_d = mem_a_q[0] ? CH_SPACE : attr_q;
          mem_we_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Cursor stays put during a scroll; it is parked at column 0 when FILL finishes.
    if (newline) begin
      if (cursor_y_q != LAST_ROW) begin
        cursor_x_d = 7'd0;
        cursor_y_d = cursor_y_q + 5'd1;
      end else begin
        state_d  = SCROLL_RD;
        mem_a_d  = ROW_BYTES;
        mem_we_d = 1'b0;
        clr_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      mem_a_q    <= 12'd0;
      mem_dw_q   <= 8'd0;
      mem_we_q   <= 1'b0;
      cursor_x_q <= 7'd0;
      cursor_y_q <= 5'd0;
      attr_q     <= 8'd0;
      clr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_a_q    <= mem_a_d;
      mem_dw_q   <= mem_dw_d;
      mem_we_q   <= mem_we_d;
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      attr_q     <= attr_d;
      clr_q      <= clr_d;
    end
  end

  // Read data only arrives in the SCROLL_WR cycle itself, so it is forwarded straight to the write port.
  assign mem_dw   = (state_q == SCROLL_WR) ? mem_dr : mem_dw_q;
  assign mem_a    = mem_a_q;
  assign mem_we   = mem_we_q;
  assign cursor_x = cursor_x_q;
  assign cursor_y = cursor_y_q;
  assign busy     = (state_q != IDLE);
  assign in_ready = (state_q == IDLE) && !clear;

endmodule

// File: tb/tb_vga_console_writer.sv
// Directed bench for vga_console_writer with a synchronous-read text memory model.
module tb_vga_console_writer;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  attr = 8'h00;
  logic        clear = 1'b0;
  logic [11:0] mem_a;
  logic [7:0]  mem_dw;
  logic        mem_we;
  logic [7:0]  mem_dr;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  logic [7:0] mem  [0:4095];
  logic [7:0] snap [0:3999];
  int wr_count  = 0;
  int range_bad = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] code;
    logic [7:0] attr;
    int exp_x;
    int exp_y;
    int exp_busy;
    int exp_writes;
    int exp_addr;
  } vec_t;

  vga_console_writer dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .attr     (attr),
    .clear    (clear),
    .mem_a    (mem_a),
    .mem_dw   (mem_dw),
    .mem_we   (mem_we),
    .mem_dr   (mem_dr),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (mem_we) begin
      mem[mem_a] <= mem_dw;
      wr_count   <= wr_count + 1;
      if (mem_a > 12'd3999) range_bad <= range_bad + 1;
    end
    mem_dr <= mem[mem_a];
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
  endtask

  // Sends one byte from a negedge with the writer idle; returns at a negedge once it is idle again.
  task automatic apply_stimulus(input logic [7:0] code, input logic [7:0] a,
                                output int busy_cycles, output int writes);
    int w0;
    bit done;
    in_data  = code;
    attr     = a;
    in_valid = 1'b1;
    w0 = wr_count;
    @(posedge sys_clk);
    #1 in_valid = 1'b0;
    busy_cycles = 0;
    done = 0;
    for (int i = 0; i < 10000 && !done; i++) begin
      @(negedge sys_clk);
      if (busy) busy_cycles++;
      else done = 1;
    end
    if (!done) check_output("busy_timeout", 1, 0);
    writes = wr_count - w0;
  endtask

  task automatic send_many(input int n, input logic [7:0] code, input logic [7:0] a);
    int b, w;
    for (int i = 0; i < n; i++) apply_stimulus(code, a, b, w);
  endtask

  initial begin
    vec_t vecs[12];
    int b, w, bad, w0, rdy_hi;
    bit done;

    for (int i = 0; i < 4096; i++) mem[i] = 8'((i * 7 + 3) ^ (i >> 5));

    vecs[0]  = '{8'h08, 8'h07, 0,  0, 0, 0, 0};
    vecs[1]  = '{8'h08, 8'h07, 0,  0, 0, 0, 0};
    vecs[2]  = '{8'h61, 8'h07, 1,  0, 2, 2, 0};
    vecs[3]  = '{8'h62, 8'h07, 2,  0, 2, 2, 2};
    vecs[4]  = '{8'h63, 8'h07, 3,  0, 2, 2, 4};
    vecs[5]  = '{8'h09, 8'h07, 8,  0, 0, 0, 0};
    vecs[6]  = '{8'h09, 8'h07, 16, 0, 0, 0, 0};
    vecs[7]  = '{8'h64, 8'h1E, 17, 0, 2, 2, 32};
    vecs[8]  = '{8'h0D, 8'h07, 0,  0, 0, 0, 0};
    vecs[9]  = '{8'h0A, 8'h07, 0,  1, 0, 0, 0};
    vecs[10] = '{8'h65, 8'h2C, 1,  1, 2, 2, 160};
    vecs[11] = '{8'h0D, 8'h07, 0,  1, 0, 0, 0};

    // Reset values
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_output("rst_mem_we", mem_we, 0);
    check_output("rst_mem_a", mem_a, 0);
    check_output("rst_mem_dw", mem_dw, 0);
    check_output("rst_cursor_x", cursor_x, 0);
    check_output("rst_cursor_y", cursor_y, 0);
    check_output("rst_busy", busy, 0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_output("rst_in_ready", in_ready, 1);

    // First character, cycle by cycle
    in_data = 8'h41; attr = 8'h07; in_valid = 1'b1;
    @(posedge sys_clk);
    #1 in_valid = 1'b0;
    @(negedge sys_clk);
    check_output("a_t1_we", mem_we, 1);
    check_output("a_t1_addr", mem_a, 12'h000);
    check_output("a_t1_data", mem_dw, 8'h41);
    check_output("a_t1_ready", in_ready, 0);
    @(negedge sys_clk);
    check_output("a_t2_we", mem_we, 1);
    check_output("a_t2_addr", mem_a, 12'h001);
    check_output("a_t2_data", mem_dw, 8'h07);
    @(negedge sys_clk);
    check_output("a_t3_we", mem_we, 0);
    check_output("a_t3_ready", in_ready, 1);
    check_output("a_t3_busy", busy, 0);
    check_output("a_cursor_x", cursor_x, 1);
    check_output("a_cursor_y", cursor_y, 0);
    check_output("a_mem0", mem[0], 8'h41);
    check_output("a_mem1", mem[1], 8'h07);

    // Table of single-byte vectors continuing from cursor (1,0)
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].code, vecs[i].attr, b, w);
      check_output($sformatf("vec%0d_x", i), cursor_x, vecs[i].exp_x);
      check_output($sformatf("vec%0d_y", i), cursor_y, vecs[i].exp_y);
      check_output($sformatf("vec%0d_busy", i), b, vecs[i].exp_busy);
      check_output($sformatf("vec%0d_writes", i), w, vecs[i].exp_writes);
      if (vecs[i].exp_writes != 0) begin
        check_output($sformatf("vec%0d_char", i), mem[vecs[i].exp_addr], vecs[i].code);
        check_output($sformatf("vec%0d_attr", i), mem[vecs[i].exp_addr + 1], vecs[i].attr);
      end
    end

    // Line wrap after 80 characters, then TAB from column 76
    apply_reset();
    send_many(80, 8'h2E, 8'h07);
    check_output("wrap_x", cursor_x, 0);
    check_output("wrap_y", cursor_y, 1);
    apply_stimulus(8'h42, 8'h07, b, w);
    check_output("wrap_b_mem", mem[12'h0A0], 8'h42);
    check_output("wrap_b_x", cursor_x, 1);
    check_output("wrap_b_y", cursor_y, 1);
    send_many(75, 8'h2E, 8'h07);
    check_output("tab76_pre_x", cursor_x, 76);
    apply_stimulus(8'h09, 8'h07, b, w);
    check_output("tab76_x", cursor_x, 0);
    check_output("tab76_y", cursor_y, 2);
    check_output("tab76_writes", w, 0);

    // Scroll from the bottom row
    apply_reset();
    apply_stimulus(8'h0A, 8'h07, b, w);
    apply_stimulus(8'h5A, 8'h33, b, w);
    send_many(23, 8'h0A, 8'h07);
    check_output("scroll_pre_y", cursor_y, 24);
    for (int i = 0; i < 4000; i++) snap[i] = mem[i];
    apply_stimulus(8'h0A, 8'h4E, b, w);
    check_output("scroll_busy", b, 7840);
    check_output("scroll_writes", w, 4000);
    check_output("scroll_mem0", mem[0], 8'h5A);
    check_output("scroll_mem1", mem[1], 8'h33);
    bad = 0;
    for (int i = 0; i < 3840; i++) if (mem[i] != snap[i + 160]) bad++;
    check_output("scroll_copy_errs", bad, 0);
    bad = 0;
    for (int i = 3840; i < 4000; i++) if (mem[i] != ((i % 2 == 0) ? 8'h20 : 8'h4E)) bad++;
    check_output("scroll_fill_errs", bad, 0);
    check_output("scroll_x", cursor_x, 0);
    check_output("scroll_y", cursor_y, 24);

    // Clear with in_valid held high throughout
    in_data = 8'h51; in_valid = 1'b1; attr = 8'h1F; clear = 1'b1;
    #1 check_output("clr_ready_low", in_ready, 0);
    w0 = wr_count;
    @(posedge sys_clk);
    #1 clear = 1'b0;
    b = 0; rdy_hi = 0; done = 0;
    for (int i = 0; i < 10000 && !done; i++) begin
      @(negedge sys_clk);
      if (busy) begin
        b++;
        if (in_ready) rdy_hi++;
      end else begin
        in_valid = 1'b0;
        done = 1;
      end
    end
    if (!done) check_output("clr_timeout", 1, 0);
    check_output("clr_busy", b, 4000);
    check_output("clr_writes", wr_count - w0, 4000);
    check_output("clr_ready_during", rdy_hi, 0);
    bad = 0;
    for (int i = 0; i < 4000; i++) if (mem[i] != ((i % 2 == 0) ? 8'h20 : 8'h1F)) bad++;
    check_output("clr_pattern_errs", bad, 0);
    check_output("clr_x", cursor_x, 0);
    check_output("clr_y", cursor_y, 0);

    // Reset in the middle of a scroll
    send_many(24, 8'h0A, 8'h07);
    in_data = 8'h0A; attr = 8'h07; in_valid = 1'b1;
    @(posedge sys_clk);
    #1 in_valid = 1'b0;
    repeat (100) @(negedge sys_clk);
    check_output("midrst_busy_before", busy, 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    w0 = wr_count;
    check_output("midrst_we", mem_we, 0);
    check_output("midrst_addr", mem_a, 0);
    check_output("midrst_x", cursor_x, 0);
    check_output("midrst_y", cursor_y, 0);
    check_output("midrst_busy", busy, 0);
    check_output("midrst_ready", in_ready, 1);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);
    check_output("midrst_no_writes", wr_count - w0, 0);
    check_output("midrst_busy_after", busy, 0);

    check_output("addr_range_violations", range_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
